// File: rtl/unfilter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unfilter_pkg
// Description : Shared widths, filter-type codes and FSM state encoding for
//               the PNG reconstruction (inverse filter) stage.
// Revision    : 1.0 - initial release
// ============================================================================
package unfilter_pkg;

    // Pixel word width; filter arithmetic runs per 8-bit lane inside it.
    localparam int DATA_PXL_WD = 8;
    // Width of the row-width and row-count configuration ports.
    localparam int SIZE_W_WD   = 12;
    localparam int SIZE_H_WD   = 12;
    // Line-buffer depth, i.e. the widest supported row in pixels.
    localparam int SIZE_W_MAX  = 64;

    // PNG filter-type codes, as carried on a row's type beat.
    typedef enum logic [2:0] {
        FLT_NONE  = 3'd0,
        FLT_SUB   = 3'd1,
        FLT_UP    = 3'd2,
        FLT_AVG   = 3'd3,
        FLT_PAETH = 3'd4
    } flt_e;

    // Control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TYPE = 2'd1,
        ST_PXL  = 2'd2,
        ST_LAST = 2'd3
    } state_e;

endpackage : unfilter_pkg
`default_nettype wire

// File: rtl/unfilter_lbuf.sv
`default_nettype none
// ============================================================================
// Module      : unfilter_lbuf
// Description : Single-clock line buffer holding the previous reconstructed
//               row. Registered read with 1-cycle latency and an independent
//               write port. A read and a write to the same address on the
//               same edge return the old contents.
// Ports       : clk, rstn     - clock, asynchronous active-low reset
//               i_we          - write enable
//               i_waddr       - write address
//               i_wdata       - write data
//               i_raddr       - read address (read every cycle)
//               o_rdata       - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module unfilter_lbuf #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage array carries no reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : unfilter_lbuf
`default_nettype wire

// File: rtl/unfilter_top.sv
`default_nettype none
// ============================================================================
// Module      : unfilter_top
// Description : PNG reconstruction stage. Consumes a filtered scanline stream
//               (one filter-type beat then cfg_w_i pixel beats per row) and
//               emits reconstructed pixels through a 2-stage pipeline. The
//               previous reconstructed row lives in unfilter_lbuf and supplies
//               the Up / Avg / Paeth references.
// Ports       : clk, rstn          - clock, asynchronous active-low reset
//               cfg_w_i, cfg_h_i   - row width / row count, sampled at start_i
//               start_i            - begins an image (honoured in IDLE only)
//               done_o             - pulse one cycle after the final val_o
//               err_o              - sticky illegal-filter-type flag
//               val_i, dat_i       - input beat (no backpressure)
//               val_o, dat_o       - reconstructed pixel
// Revision    : 1.0 - initial release
// ============================================================================
module unfilter_top
    import unfilter_pkg::*;
#(
    parameter int BYTE_N = DATA_PXL_WD / 8,
    parameter int W_MAX  = SIZE_W_MAX
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [SIZE_W_WD-1:0]  cfg_w_i,
    input  logic [SIZE_H_WD-1:0]  cfg_h_i,
    input  logic                  start_i,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  val_i,
    input  logic [8*BYTE_N-1:0]   dat_i,
    output logic                  val_o,
    output logic [8*BYTE_N-1:0]   dat_o
);

    localparam int PXL_WD = 8 * BYTE_N;
    localparam int AW     = (W_MAX > 1) ? $clog2(W_MAX) : 1;

    // ------------------------------------------------------------------
    // Per-lane predictors
    // ------------------------------------------------------------------
    function automatic logic [7:0] paeth_pred(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] c);
        logic signed [9:0] p;
        logic signed [9:0] pa;
        logic signed [9:0] pb;
        logic signed [9:0] pc;
        logic [7:0]        res;
        p  = $signed({2'b00, a}) + $signed({2'b00, b}) - $signed({2'b00, c});
        pa = p - $signed({2'b00, a});
        pb = p - $signed({2'b00, b});
        pc = p - $signed({2'b00, c});
        if (pa[9]) pa = -pa;
        if (pb[9]) pb = -pb;
        if (pc[9]) pc = -pc;
        // Ties resolve in the order a, b, c.
        if (pa <= pb && pa <= pc) begin
            res = a;
        end else if (pb <= pc) begin
            res = b;
        end else begin
            res = c;
        end
        return res;
    endfunction

    function automatic logic [7:0] lane_recon(input flt_e       ft,
                                              input logic [7:0] x,
                                              input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] c);
        logic [8:0] sum;
        logic [7:0] pred;
        // Avg needs the carry of a+b before halving.
        sum = {1'b0, a} + {1'b0, b};
        case (ft)
            FLT_SUB:   pred = a;
            FLT_UP:    pred = b;
            FLT_AVG:   pred = sum[8:1];
            FLT_PAETH: pred = paeth_pred(a, b, c);
            default:   pred = 8'd0;
        endcase
        return x + pred;
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_e               r_state;
    logic [SIZE_W_WD-1:0] r_w;
    logic [SIZE_H_WD-1:0] r_h;
    logic [SIZE_W_WD-1:0] r_cnt_w;
    logic [SIZE_H_WD-1:0] r_cnt_h;
    flt_e                 r_ftype;
    logic                 r_done;
    logic                 r_err;

    // Pipeline registers (declared here, the FSM watches the tail).
    logic                 r_s0_val;
    logic [PXL_WD-1:0]    r_s0_x;
    flt_e                 r_s0_ft;
    logic                 r_s0_col0;
    logic                 r_s0_row0;
    logic [AW-1:0]        r_s0_col;
    logic                 r_val_o;
    logic [PXL_WD-1:0]    r_dat_o;
    logic [PXL_WD-1:0]    r_c;

    logic                 w_pxl_fire;
    logic [PXL_WD-1:0]    w_lb_rdata;
    logic [PXL_WD-1:0]    w_a;
    logic [PXL_WD-1:0]    w_b;
    logic [PXL_WD-1:0]    w_c;
    logic [PXL_WD-1:0]    w_recon;

    assign w_pxl_fire = (r_state == ST_PXL) && val_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_w     <= '0;
            r_h     <= '0;
            r_cnt_w <= '0;
            r_cnt_h <= '0;
            r_ftype <= FLT_NONE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_w     <= cfg_w_i;
                        r_h     <= cfg_h_i;
                        r_cnt_w <= '0;
                        r_cnt_h <= '0;
                        r_err   <= 1'b0;
                        r_state <= ST_TYPE;
                    end
                end
                ST_TYPE: begin
                    if (val_i) begin
                        // Unknown filter types reconstruct as None.
                        if (dat_i[7:0] > 8'd4) begin
                            r_ftype <= FLT_NONE;
                            r_err   <= 1'b1;
                        end else begin
                            r_ftype <= flt_e'(dat_i[2:0]);
                        end
                        r_state <= ST_PXL;
                    end
                end
                ST_PXL: begin
                    if (val_i) begin
                        if (r_cnt_w == r_w - 1'b1) begin
                            r_cnt_w <= '0;
                            if (r_cnt_h == r_h - 1'b1) begin
                                r_state <= ST_LAST;
                            end else begin
                                r_cnt_h <= r_cnt_h + 1'b1;
                                r_state <= ST_TYPE;
                            end
                        end else begin
                            r_cnt_w <= r_cnt_w + 1'b1;
                        end
                    end
                end
                ST_LAST: begin
                    // The final pixel is the one on val_o once nothing is
                    // left behind it in S0.
                    if (r_val_o && !r_s0_val) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line buffer: read at S0 column, write-back from S1
    // ------------------------------------------------------------------
    unfilter_lbuf #(
        .DEPTH (W_MAX),
        .WIDTH (PXL_WD),
        .AW    (AW)
    ) u_lbuf (
        .clk     (clk),
        .rstn    (rstn),
        .i_we    (r_s0_val),
        .i_waddr (r_s0_col),
        .i_wdata (w_recon),
        .i_raddr (r_cnt_w[AW-1:0]),
        .o_rdata (w_lb_rdata)
    );

    // ------------------------------------------------------------------
    // S1 references: a chains from the output register, c is the b of the
    // previous pixel. Row 0 masks the stale line-buffer contents.
    // ------------------------------------------------------------------
    assign w_b = r_s0_row0 ? '0 : w_lb_rdata;
    assign w_a = r_s0_col0 ? '0 : r_dat_o;
    assign w_c = (r_s0_row0 || r_s0_col0) ? '0 : r_c;

    always_comb begin
        w_recon = '0;
        for (int i = 0; i < BYTE_N; i++) begin
            w_recon[8*i +: 8] = lane_recon(r_s0_ft, r_s0_x[8*i +: 8],
                                           w_a[8*i +: 8], w_b[8*i +: 8],
                                           w_c[8*i +: 8]);
        end
    end

    // ------------------------------------------------------------------
    // Pipeline S0 / S1
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s0_val  <= 1'b0;
            r_s0_x    <= '0;
            r_s0_ft   <= FLT_NONE;
            r_s0_col0 <= 1'b0;
            r_s0_row0 <= 1'b0;
            r_s0_col  <= '0;
            r_val_o   <= 1'b0;
            r_dat_o   <= '0;
            r_c       <= '0;
        end else begin
            r_s0_val <= w_pxl_fire;
            if (w_pxl_fire) begin
                r_s0_x    <= dat_i;
                r_s0_ft   <= r_ftype;
                r_s0_col0 <= (r_cnt_w == '0);
                r_s0_row0 <= (r_cnt_h == '0);
                r_s0_col  <= r_cnt_w[AW-1:0];
            end
            r_val_o <= r_s0_val;
            // dat_o holds across gaps so a stays valid for the next pixel.
            if (r_s0_val) begin
                r_dat_o <= w_recon;
                r_c     <= w_b;
            end
        end
    end

    assign done_o = r_done;
    assign err_o  = r_err;
    assign val_o  = r_val_o;
    assign dat_o  = r_dat_o;

endmodule : unfilter_top
`default_nettype wire

// File: tb/tb_unfilter_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_unfilter_top
// Description : Self-checking bench for unfilter_top. Images are described as
//               arrays of filter types and filtered bytes; the expected raw
//               image is rebuilt from the PNG reconstruction rules with plain
//               integer arithmetic, and a timed scoreboard checks data, the
//               2-cycle latency, done_o timing, err_o and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unfilter_top;
    import unfilter_pkg::*;

    logic                 clk;
    logic                 rstn;
    logic [SIZE_W_WD-1:0] cfg_w_i;
    logic [SIZE_H_WD-1:0] cfg_h_i;
    logic                 start_i;
    logic                 done_o;
    logic                 err_o;
    logic                 val_i;
    logic [7:0]           dat_i;
    logic                 val_o;
    logic [7:0]           dat_o;

    unfilter_top #(
        .BYTE_N (1),
        .W_MAX  (SIZE_W_MAX)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .cfg_w_i (cfg_w_i),
        .cfg_h_i (cfg_h_i),
        .start_i (start_i),
        .done_o  (done_o),
        .err_o   (err_o),
        .val_i   (val_i),
        .dat_i   (dat_i),
        .val_o   (val_o),
        .dat_o   (dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc          = 0;
    int   n_cmp        = 0;
    int   n_err        = 0;
    int   exp_done_cyc = -1;
    bit   done_seen    = 1'b0;
    int   done_cnt     = 0;

    int g_w;
    int g_h;
    int g_t [8];
    int g_x [8][16];
    int g_r [8][16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference predictor straight from the PNG rules.
    function automatic int ref_pred(input int t, input int a, input int b, input int c);
        int p, pa, pb, pc, r;
        r = 0;
        case (t)
            1: r = a;
            2: r = b;
            3: r = (a + b) / 2;
            4: begin
                p  = a + b - c;
                pa = (p > a) ? p - a : a - p;
                pb = (p > b) ? p - b : b - p;
                pc = (p > c) ? p - c : c - p;
                if (pa <= pb && pa <= pc) r = a;
                else if (pb <= pc)        r = b;
                else                      r = c;
            end
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic build_ref(output bit e);
        int a, b, c;
        e = 1'b0;
        for (int r = 0; r < g_h; r++) begin
            if (g_t[r] > 4) e = 1'b1;
            for (int col = 0; col < g_w; col++) begin
                a = (col > 0) ? g_r[r][col-1] : 0;
                b = (r > 0) ? g_r[r-1][col] : 0;
                c = (r > 0 && col > 0) ? g_r[r-1][col-1] : 0;
                g_r[r][col] = (g_x[r][col] + ref_pred(g_t[r], a, b, c)) % 256;
            end
        end
    endtask

    // Output monitor: timed scoreboard plus done_o timing.
    always @(negedge clk) begin
        if (rstn) begin
            if (val_o) begin
                if (q.size() == 0) begin
                    check_val("val_o_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check_val("dat_o", int'(dat_o), e.d);
                    check_val("val_o_latency", cyc, e.cyc);
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                check_val("val_o_missing", 0, 1);
                void'(q.pop_front());
            end
            if (done_o) begin
                done_seen = 1'b1;
                done_cnt++;
                check_val("done_cycle", cyc, exp_done_cyc);
            end
        end
    end

    task automatic idle_cycles(input int n, input bit poke_start);
        for (int i = 0; i < n; i++) begin
            val_i = 1'b0;
            dat_i = 8'($urandom_range(0, 255));
            // start_i outside IDLE must be ignored.
            start_i = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_w_i = SIZE_W_WD'($urandom_range(1, 16));
            cfg_h_i = SIZE_H_WD'($urandom_range(1, 6));
            @(posedge clk); #1;
        end
        start_i = 1'b0;
    endtask

    // Drives the image in g_*; abort_row >= 0 resets mid-row on that row.
    task automatic run_image(input int abort_row);
        bit exp_err;
        int lastc;
        int snap;
        lastc = 0;
        build_ref(exp_err);
        start_i = 1'b1;
        cfg_w_i = SIZE_W_WD'(g_w);
        cfg_h_i = SIZE_H_WD'(g_h);
        @(posedge clk); #1;
        start_i = 1'b0;
        check_val("err_o_cleared_by_start", int'(err_o), 0);
        for (int r = 0; r < g_h; r++) begin
            idle_cycles($urandom_range(0, 2), 1'b1);
            val_i = 1'b1;
            dat_i = 8'(g_t[r]);
            @(posedge clk); #1;
            val_i = 1'b0;
            for (int col = 0; col < g_w; col++) begin
                if (r == abort_row && col == 2) begin
                    snap = done_cnt;
                    rstn = 1'b0;
                    #1;
                    check_val("rst_val_o", int'(val_o), 0);
                    check_val("rst_dat_o", int'(dat_o), 0);
                    check_val("rst_done_o", int'(done_o), 0);
                    check_val("rst_err_o", int'(err_o), 0);
                    q.delete();
                    repeat (2) @(posedge clk);
                    #1;
                    rstn = 1'b1;
                    repeat (10) @(posedge clk);
                    #1;
                    check_val("no_done_after_abort", done_cnt, snap);
                    return;
                end
                if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2), 1'b1);
                val_i = 1'b1;
                dat_i = 8'(g_x[r][col]);
                q.push_back('{d: g_r[r][col], cyc: cyc + 2});
                lastc = cyc;
                @(posedge clk); #1;
                val_i = 1'b0;
            end
        end
        exp_done_cyc = lastc + 3;
        done_seen    = 1'b0;
        for (int i = 0; i < 20 && !done_seen; i++) begin
            @(posedge clk); #1;
        end
        if (!done_seen) check_val("done_timeout", 0, 1);
        check_val("err_o", int'(err_o), int'(exp_err));
        check_val("scoreboard_drained", q.size(), 0);
        // A beat in IDLE must be dropped.
        val_i = 1'b1;
        dat_i = 8'($urandom_range(0, 255));
        @(posedge clk); #1;
        val_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int r, input int t, input int x0, input int x1,
                           input int x2, input int x3);
        g_t[r]    = t;
        g_x[r][0] = x0;
        g_x[r][1] = x1;
        g_x[r][2] = x2;
        g_x[r][3] = x3;
    endtask

    initial begin
        rstn    = 1'b0;
        start_i = 1'b0;
        val_i   = 1'b0;
        dat_i   = 8'd0;
        cfg_w_i = '0;
        cfg_h_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_val_o", int'(val_o), 0);
        check_val("reset_dat_o", int'(dat_o), 0);
        check_val("reset_done_o", int'(done_o), 0);
        check_val("reset_err_o", int'(err_o), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // None, single row.
        g_w = 4; g_h = 1;
        set_row(0, 0, 1, 2, 3, 4);
        run_image(-1);

        // Sub then Up.
        g_w = 4; g_h = 2;
        set_row(0, 1, 10, 1, 1, 1);
        set_row(1, 2, 1, 1, 1, 1);
        run_image(-1);

        // Avg with 9-bit sum, then Sub wrap-around.
        g_w = 2; g_h = 3;
        set_row(0, 0, 255, 255, 0, 0);
        set_row(1, 3, 128, 0, 0, 0);
        set_row(2, 1, 200, 100, 0, 0);
        run_image(-1);

        // Paeth tie picks a (a=10,b=10,c=5).
        g_w = 2; g_h = 2;
        set_row(0, 0, 5, 10, 0, 0);
        set_row(1, 4, 5, 0, 0, 0);
        run_image(-1);

        // Paeth picks b (a=10,b=20,c=10).
        g_w = 2; g_h = 2;
        set_row(0, 0, 10, 20, 0, 0);
        set_row(1, 4, 0, 0, 0, 0);
        run_image(-1);

        // Illegal type on a 1x1 image; next start clears err_o.
        g_w = 1; g_h = 1;
        set_row(0, 7, 9, 0, 0, 0);
        run_image(-1);

        // Reset in the middle of row 1, then a clean restart.
        g_w = 4; g_h = 3;
        set_row(0, 1, 3, 4, 5, 6);
        set_row(1, 2, 7, 8, 9, 10);
        set_row(2, 0, 1, 1, 1, 1);
        run_image(1);
        g_w = 2; g_h = 1;
        set_row(0, 0, 5, 6, 0, 0);
        run_image(-1);

        // Randomized images.
        for (int n = 0; n < 25; n++) begin
            g_w = $urandom_range(1, 16);
            g_h = $urandom_range(1, 6);
            for (int r = 0; r < g_h; r++) begin
                g_t[r] = ($urandom_range(0, 19) == 0) ? $urandom_range(5, 255)
                                                      : $urandom_range(0, 4);
                for (int col = 0; col < g_w; col++) begin
                    g_x[r][col] = $urandom_range(0, 255);
                end
            end
            run_image(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_unfilter_top
`default_nettype wire
